// File: rtl/insn_prefetch_buf.sv
// Instruction prefetch buffer: issues sequential word fetches to the scratchpad and queues
// {pc, insn} pairs in a small FIFO for the IF stage; a branch redirect flushes everything.
module insn_prefetch_buf #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic        br_taken,
  input  logic [29:0] br_addr,
  output logic [29:0] fetch_addr,
  output logic        fetch_as_,
  input  logic [31:0] fetch_rd_data,
  output logic        buf_valid,
  output logic [29:0] buf_pc,
  output logic [31:0] buf_insn,
  input  logic        if_ready
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  logic [29:0]     fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [29:0]     inflight_pc_q, inflight_pc_d;
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] occupancy;
  logic            issue, push, pop;

  logic [29:0] pc_mem   [DEPTH];
  logic [31:0] insn_mem [DEPTH];

  always_comb begin
    // An in-flight word already owns a slot, so it counts against capacity.
    occupancy = count_q + CntW'(inflight_q);
    issue     = ~reset & cpu_en & ~br_taken & (occupancy < DepthC);
    push      = inflight_q & ~br_taken;
    buf_valid = (count_q != '0) & ~br_taken;
    pop       = buf_valid & if_ready;

    fetch_addr = fetch_pc_q;
    fetch_as_  = ~issue;
    buf_pc     = pc_mem[rptr_q];
    buf_insn   = insn_mem[rptr_q];

    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    count_d       = count_q;

    if (br_taken) begin
      fetch_pc_d = br_addr;
      inflight_d = 1'b0;
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + 30'd1;
        inflight_pc_d = fetch_pc_q;
      end
      if (push) wptr_d = wptr_q + PtrW'(1);
      if (pop)  rptr_d = rptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: entries are only observable once count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wptr_q]   <= inflight_pc_q;
      insn_mem[wptr_q] <= fetch_rd_data;
    end
  end

endmodule

// File: doc/insn_prefetch_buf.md
INSN_PREFETCH_BUF -- requirements
Module: insn_prefetch_buf

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning prefetch FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 30'h0, meaning first word address fetched after reset.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, meaning asynchronous active-high reset.
REQ-005 The block SHALL have port cpu_en, input, 1 bit, meaning fetch enable; low blocks new fetch requests.
REQ-006 The block SHALL have port br_taken, input, 1 bit, meaning redirect/flush request from decode.
REQ-007 The block SHALL have port br_addr, input, 30 bits, meaning redirect word address.
REQ-008 The block SHALL have port fetch_addr, output, 30 bits, meaning spm instruction-port word address.
REQ-009 The block SHALL have port fetch_as_, output, 1 bit, meaning spm instruction-port strobe, active low.
REQ-010 The block SHALL have port fetch_rd_data, input, 32 bits, meaning spm read data, valid one cycle after strobe.
REQ-011 The block SHALL have port buf_valid, output, 1 bit, meaning buf_pc/buf_insn hold a valid entry.
REQ-012 The block SHALL have port buf_pc, output, 30 bits, meaning word address of head entry.
REQ-013 The block SHALL have port buf_insn, output, 32 bits, meaning instruction of head entry.
REQ-014 The block SHALL have port if_ready, input, 1 bit, meaning IF stage accepts head entry this cycle.

Function
REQ-015 The block SHALL keep fetch_pc (30 b), an in-flight flag with captured request pc, and a DEPTH-entry FIFO of {pc, insn} with read/write pointers and a count of 0..DEPTH.
REQ-016 The block SHALL issue a request (fetch_as_=0, fetch_addr=fetch_pc) when cpu_en=1, br_taken=0 and count + in-flight < DEPTH; otherwise fetch_as_=1.
REQ-017 On issue, the block SHALL advance fetch_pc by 1 modulo 2^30 (3FFFFFFF wraps to 0) and set in-flight with the issued pc.
REQ-018 In the cycle after an issue, the block SHALL write {captured pc, fetch_rd_data} at the write pointer, unless killed by REQ-022.
REQ-019 buf_valid SHALL equal (count != 0) and br_taken=0; buf_pc/buf_insn SHALL show the entry at the read pointer.
REQ-020 A pop SHALL occur when buf_valid=1 and if_ready=1; the read pointer advances.
REQ-021 A simultaneous push and pop SHALL leave count unchanged; the issue rule guarantees count never exceeds DEPTH, and a pop with count=0 never occurs.
REQ-022 When br_taken=1, at the clock edge the block SHALL clear count and both pointers, drop any in-flight response, and load fetch_pc=br_addr; no issue occurs in that cycle; flush overrides push and pop.
REQ-023 After a flush, the first request from br_addr SHALL issue in the next cycle with cpu_en=1.
REQ-024 Minimum latency from issue to buf_valid SHALL be 2 cycles (issue in N, write at end of N+1, visible in N+2).
REQ-025 With cpu_en=0, an already in-flight response SHALL still be written, and FIFO contents and pop behaviour SHALL be unaffected.
REQ-026 Steady state with if_ready held at 1 SHALL deliver one instruction per cycle, in address order.

Reset
REQ-027 Asserting reset SHALL immediately set fetch_pc=RESET_PC, count=0, pointers=0, in-flight=0, fetch_as_=1 and buf_valid=0, regardless of the clock.
REQ-028 Reset asserted mid-request SHALL discard the response; the first request after release SHALL be at RESET_PC.

Verification
REQ-029 Reset release, cpu_en=1, if_ready=1, spm returns addr+0x100 -> fetch_addr 0,1,2,... on consecutive cycles; buf_valid from cycle 2; buf_pc 0,1,2 with buf_insn 0x100,0x101,0x102.
REQ-030 if_ready=0, cpu_en=1 -> exactly 4 requests (addr 0..3), then fetch_as_ held at 1 with count=4; raising if_ready for 1 cycle -> one pop and one new request at addr 4.
REQ-031 br_taken=1, br_addr=0x40 while 3 entries are held and a request is in flight -> buf_valid=0 in that cycle; next cycle fetch_addr=0x40; first buf_pc after the flush is 0x40, never a stale address.
REQ-032 fetch_pc=0x3FFFFFFF -> successive requests at 0x3FFFFFFF then 0x0, both delivered in order.
REQ-033 cpu_en dropped in the cycle after an issue -> the response is still buffered, no further requests issue, and the FIFO drains normally via if_ready.
REQ-034 Async reset pulse between clock edges while full -> outputs clear before the next edge; after release the first fetch_addr is RESET_PC.
